// File: rtl/counter_cmd_sequencer.sv
// Command sequencer for the lab up/down counter: turns LOAD / UP-N / DOWN-N /
// HOLD-N requests into cycle-by-cycle en/dir/load/data pin activity.
//
// Handshake: a command is taken on the rising edge where cmd_valid && cmd_ready.
// cmd_ready is high only while IDLE, and cmd_op/cmd_arg are sampled on that edge
// only. cmd_valid is ignored in every other state.
module counter_cmd_sequencer #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic [WIDTH-1:0] cnt_out,
  output logic             cnt_en,
  output logic             cnt_dir,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_data,
  output logic             done,
  output logic             sat,
  output logic             err,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [1:0]       OP_LOAD = 2'b00;
  localparam logic [1:0]       OP_UP   = 2'b01;
  localparam logic [1:0]       OP_HOLD = 2'b11;
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic             dir_q, dir_d;

  logic             cmd_ready_q, cmd_ready_d;
  logic             cnt_en_q, cnt_en_d;
  logic             cnt_dir_q, cnt_dir_d;
  logic             cnt_load_q, cnt_load_d;
  logic [WIDTH-1:0] cnt_data_q, cnt_data_d;
  logic             done_q, done_d;
  logic             sat_q, sat_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic             at_limit;

  // Next state, step counter and completion flags.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    sat_d       = 1'b0;
    err_d       = 1'b0;
    // Values above MAX_VAL (e.g. 15) never match either limit and keep running.
    at_limit    = dir_q ? (cnt_out == MAX_W) : (cnt_out == '0);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_LOAD) begin
            if (cmd_arg > MAX_W) begin
              state_d = S_DONE;
              err_d   = 1'b1;
            end else begin
              state_d = S_LOAD;
            end
          end else if (cmd_arg == '0) begin
            state_d = S_DONE;
          end else if (cmd_op == OP_HOLD) begin
            state_d     = S_WAIT;
            remaining_d = cmd_arg;
          end else begin
            state_d     = S_RUN;
            remaining_d = cmd_arg;
            dir_d       = (cmd_op == OP_UP);
          end
        end
      end
      S_LOAD: state_d = S_DONE;
      S_RUN: begin
        // Saturation wins over the step count; that cycle's enable was a no-op.
        if (at_limit) begin
          state_d = S_DONE;
          sat_d   = 1'b1;
        end else if (remaining_q == ONE_W) begin
          state_d = S_DONE;
        end else begin
          remaining_d = remaining_q - ONE_W;
        end
      end
      S_WAIT: begin
        if (remaining_q == ONE_W) begin
          state_d = S_DONE;
        end else begin
          remaining_d = remaining_q - ONE_W;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore decode of the next state so every output is a flop.
  always_comb begin
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    cnt_en_d    = (state_d == S_LOAD) || (state_d == S_RUN);
    cnt_load_d  = (state_d == S_LOAD);
    cnt_dir_d   = (state_d == S_RUN) && dir_d;
    cnt_data_d  = (state_d == S_LOAD) ? cmd_arg : '0;
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      dir_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      cnt_en_q    <= 1'b0;
      cnt_dir_q   <= 1'b0;
      cnt_load_q  <= 1'b0;
      cnt_data_q  <= '0;
      done_q      <= 1'b0;
      sat_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      cmd_ready_q <= cmd_ready_d;
      cnt_en_q    <= cnt_en_d;
      cnt_dir_q   <= cnt_dir_d;
      cnt_load_q  <= cnt_load_d;
      cnt_data_q  <= cnt_data_d;
      done_q      <= done_d;
      sat_q       <= sat_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign cnt_en    = cnt_en_q;
  assign cnt_dir   = cnt_dir_q;
  assign cnt_load  = cnt_load_q;
  assign cnt_data  = cnt_data_q;
  assign done      = done_q;
  assign sat       = sat_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule
